// File: rtl/snake_pkg.sv
// snake_pkg: shared direction encoding, grid limits, reset geometry and coordinate type.
package snake_pkg;
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;
    localparam int GRID_H_MAX     = 31;
    localparam int GRID_V_MAX     = 23;
    localparam int SNAKE_INIT_LEN = 3;
    localparam int SNAKE_MAX_LEN  = 32;
    typedef struct packed {
        logic [4:0] x;
        logic [4:0] y;
    } coord_t;
    localparam coord_t RST_HEAD = '{x: 5'd8, y: 5'd12};
endpackage

// File: rtl/snake_next_head.sv
// snake_next_head: wrapped one-cell move of a head coordinate in a given direction.
module snake_next_head import snake_pkg::*; #(
    parameter int H_LOGIC_WIDTH = 5,
    parameter int V_LOGIC_WIDTH = 5,
    parameter int H_LOGIC_MAX   = GRID_H_MAX,
    parameter int V_LOGIC_MAX   = GRID_V_MAX
) (
    input  logic [H_LOGIC_WIDTH-1:0] i_x,
    input  logic [V_LOGIC_WIDTH-1:0] i_y,
    input  logic [1:0]               i_dir,
    output logic [H_LOGIC_WIDTH-1:0] o_x,
    output logic [V_LOGIC_WIDTH-1:0] o_y
);
    localparam logic [H_LOGIC_WIDTH-1:0] X_MAX = H_LOGIC_WIDTH'(H_LOGIC_MAX);
    localparam logic [V_LOGIC_WIDTH-1:0] Y_MAX = V_LOGIC_WIDTH'(V_LOGIC_MAX);
    localparam logic [H_LOGIC_WIDTH-1:0] X_ONE = H_LOGIC_WIDTH'(1);
    localparam logic [V_LOGIC_WIDTH-1:0] Y_ONE = V_LOGIC_WIDTH'(1);

    // up decreases Y (screen coordinates)
    always_comb begin
        o_x = i_dir == DIR_RIGHT ? (i_x == X_MAX ? '0 : i_x + X_ONE) :
              i_dir == DIR_LEFT  ? (i_x == '0 ? X_MAX : i_x - X_ONE) : i_x;
        o_y = i_dir == DIR_DOWN  ? (i_y == Y_MAX ? '0 : i_y + Y_ONE) :
              i_dir == DIR_UP    ? (i_y == '0 ? Y_MAX : i_y - Y_ONE) : i_y;
    end
endmodule

// File: rtl/snake_body.sv
// snake_body: snake movement, segment storage, occupancy query and self-collision detection.
module snake_body import snake_pkg::*; #(
    parameter int H_LOGIC_WIDTH = 5,
    parameter int V_LOGIC_WIDTH = 5,
    parameter int H_LOGIC_MAX   = GRID_H_MAX,
    parameter int V_LOGIC_MAX   = GRID_V_MAX,
    parameter int MAX_LEN       = SNAKE_MAX_LEN,
    parameter int INIT_LEN      = SNAKE_INIT_LEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     step,
    input  logic                     dir_valid,
    input  logic [1:0]               dir_req,
    input  logic                     is_eat,
    input  logic [H_LOGIC_WIDTH-1:0] query_x,
    input  logic [V_LOGIC_WIDTH-1:0] query_y,
    output logic [H_LOGIC_WIDTH-1:0] head_x,
    output logic [V_LOGIC_WIDTH-1:0] head_y,
    output logic [9:0]               length,
    output logic                     query_hit,
    output logic                     moved,
    output logic                     game_over
);
    typedef enum logic {S_RUN, S_DEAD} state_t;

    state_t                   r_state, w_state_nxt;
    logic [H_LOGIC_WIDTH-1:0] r_seg_x [MAX_LEN];
    logic [V_LOGIC_WIDTH-1:0] r_seg_y [MAX_LEN];
    logic [9:0]               r_len;
    logic [1:0]               r_dir, r_dir_pend;
    logic                     r_eat_pend, r_moved;
    logic [H_LOGIC_WIDTH-1:0] w_nx;
    logic [V_LOGIC_WIDTH-1:0] w_ny;
    logic [9:0]               w_lim;
    logic                     w_run, w_grow, w_collide, w_commit, w_dir_ok;

    snake_next_head #(
        .H_LOGIC_WIDTH(H_LOGIC_WIDTH), .V_LOGIC_WIDTH(V_LOGIC_WIDTH),
        .H_LOGIC_MAX(H_LOGIC_MAX), .V_LOGIC_MAX(V_LOGIC_MAX)
    ) u_next (
        .i_x(r_seg_x[0]), .i_y(r_seg_y[0]), .i_dir(r_dir_pend), .o_x(w_nx), .o_y(w_ny)
    );

    // without growth the tail slot vacates this step, so it is excluded from the collision set
    always_comb begin
        w_run     = r_state == S_RUN;
        w_grow    = (r_eat_pend || is_eat) && r_len < 10'(MAX_LEN);
        w_lim     = w_grow ? r_len : r_len - 10'd1;
        w_collide = 1'b0;
        query_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_collide = w_collide | (10'(i) < w_lim && r_seg_x[i] == w_nx && r_seg_y[i] == w_ny);
            query_hit = query_hit | (10'(i) < r_len && r_seg_x[i] == query_x && r_seg_y[i] == query_y);
        end
        w_commit    = w_run && step && !w_collide;
        w_dir_ok    = w_run && dir_valid && dir_req != (r_dir ^ 2'd2);
        w_state_nxt = w_run && step && w_collide ? S_DEAD : r_state;
    end

    always_ff @(posedge clk)
        r_state <= rst ? S_RUN : w_state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= H_LOGIC_WIDTH'(int'(RST_HEAD.x) - i);
                r_seg_y[i] <= V_LOGIC_WIDTH'(RST_HEAD.y);
            end
            r_len      <= 10'(INIT_LEN);
            r_dir      <= DIR_RIGHT;
            r_dir_pend <= DIR_RIGHT;
            r_eat_pend <= 1'b0;
            r_moved    <= 1'b0;
        end else begin
            r_moved <= w_commit;
            if (w_dir_ok)
                r_dir_pend <= dir_req;
            if (w_commit) begin
                r_dir      <= r_dir_pend;
                r_eat_pend <= 1'b0;
                r_len      <= r_len + 10'(w_grow);
                r_seg_x[0] <= w_nx;
                r_seg_y[0] <= w_ny;
                for (int i = 1; i < MAX_LEN; i++) begin
                    r_seg_x[i] <= r_seg_x[i-1];
                    r_seg_y[i] <= r_seg_y[i-1];
                end
            end else if (w_run && is_eat)
                r_eat_pend <= 1'b1;
        end
    end

    assign head_x    = r_seg_x[0];
    assign head_y    = r_seg_y[0];
    assign length    = r_len;
    assign moved     = r_moved;
    assign game_over = r_state == S_DEAD;
endmodule

// File: tb/tb_snake_body.sv
// tb_snake_body: directed vector table plus hand-written multi-cycle sequences for snake_body.
module tb_snake_body;
    import snake_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       step = 1'b0, dir_valid = 1'b0, is_eat = 1'b0;
    logic [1:0] dir_req = 2'd0;
    logic [4:0] query_x = 5'd0, query_y = 5'd0;
    logic [4:0] head_x, head_y;
    logic [9:0] length;
    logic       query_hit, moved, game_over;
    int         n_tests = 0, n_fail = 0;

    typedef struct {
        logic       rst, step, dv;
        logic [1:0] dir;
        logic       eat;
        logic [4:0] qx, qy;
        logic [4:0] hx, hy;
        logic [9:0] len;
        logic       hit, mv, go;
    } vec_t;

    vec_t tv [15];

    snake_body dut (
        .clk(clk), .rst(rst), .step(step), .dir_valid(dir_valid), .dir_req(dir_req),
        .is_eat(is_eat), .query_x(query_x), .query_y(query_y), .head_x(head_x),
        .head_y(head_y), .length(length), .query_hit(query_hit), .moved(moved),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input logic s, input logic dv, input logic [1:0] d, input logic e);
        step = s;
        dir_valid = dv;
        dir_req = d;
        is_eat = e;
        @(posedge clk);
        #1;
        step = 1'b0;
        dir_valid = 1'b0;
        is_eat = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic st(input string n, input int hx, input int hy, input int len, input int go);
        chk({n, ".hx"}, int'(head_x), hx);
        chk({n, ".hy"}, int'(head_y), hy);
        chk({n, ".len"}, int'(length), len);
        chk({n, ".go"}, int'(game_over), go);
    endtask

    task automatic qchk(input string n, input int x, input int y, input int exp);
        query_x = 5'(x);
        query_y = 5'(y);
        #1;
        chk(n, int'(query_hit), exp);
    endtask

    initial begin
        //        rst   step  dv    dir  eat   qx     qy      hx     hy     len    hit   mv    go
        tv[0]  = '{1'b1,1'b0,1'b0,2'd0,1'b0, 5'd6, 5'd12,  5'd8, 5'd12, 10'd3,1'b1,1'b0,1'b0};
        tv[1]  = '{1'b0,1'b0,1'b0,2'd0,1'b0, 5'd5, 5'd12,  5'd8, 5'd12, 10'd3,1'b0,1'b0,1'b0};
        tv[2]  = '{1'b0,1'b1,1'b0,2'd0,1'b0, 5'd8, 5'd12,  5'd9, 5'd12, 10'd3,1'b1,1'b1,1'b0};
        tv[3]  = '{1'b0,1'b1,1'b0,2'd0,1'b0, 5'd7, 5'd12, 5'd10, 5'd12, 10'd3,1'b0,1'b1,1'b0};
        tv[4]  = '{1'b0,1'b1,1'b0,2'd0,1'b0, 5'd9, 5'd12, 5'd11, 5'd12, 10'd3,1'b1,1'b1,1'b0};
        tv[5]  = '{1'b0,1'b0,1'b1,2'd3,1'b0, 5'd8, 5'd12, 5'd11, 5'd12, 10'd3,1'b0,1'b0,1'b0};
        tv[6]  = '{1'b0,1'b1,1'b0,2'd0,1'b0,5'd11, 5'd12, 5'd12, 5'd12, 10'd3,1'b1,1'b1,1'b0};
        tv[7]  = '{1'b0,1'b0,1'b1,2'd2,1'b0,5'd12, 5'd13, 5'd12, 5'd12, 10'd3,1'b0,1'b0,1'b0};
        tv[8]  = '{1'b0,1'b1,1'b0,2'd0,1'b0,5'd12, 5'd12, 5'd12, 5'd13, 10'd3,1'b1,1'b1,1'b0};
        tv[9]  = '{1'b0,1'b1,1'b1,2'd1,1'b0,5'd12, 5'd14, 5'd12, 5'd14, 10'd3,1'b1,1'b1,1'b0};
        tv[10] = '{1'b0,1'b1,1'b0,2'd0,1'b0,5'd12, 5'd13, 5'd13, 5'd14, 10'd3,1'b1,1'b1,1'b0};
        tv[11] = '{1'b0,1'b0,1'b1,2'd0,1'b0,5'd13, 5'd13, 5'd13, 5'd14, 10'd3,1'b0,1'b0,1'b0};
        tv[12] = '{1'b0,1'b0,1'b1,2'd3,1'b0,5'd12, 5'd14, 5'd13, 5'd14, 10'd3,1'b1,1'b0,1'b0};
        tv[13] = '{1'b0,1'b1,1'b0,2'd0,1'b0,5'd13, 5'd14, 5'd13, 5'd13, 10'd3,1'b1,1'b1,1'b0};
        tv[14] = '{1'b1,1'b1,1'b0,2'd0,1'b0,5'd13, 5'd13,  5'd8, 5'd12, 10'd3,1'b0,1'b0,1'b0};

        for (int i = 0; i < 15; i++) begin
            rst = tv[i].rst;
            step = tv[i].step;
            dir_valid = tv[i].dv;
            dir_req = tv[i].dir;
            is_eat = tv[i].eat;
            query_x = tv[i].qx;
            query_y = tv[i].qy;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.hx", i), int'(head_x), int'(tv[i].hx));
            chk($sformatf("vec%0d.hy", i), int'(head_y), int'(tv[i].hy));
            chk($sformatf("vec%0d.len", i), int'(length), int'(tv[i].len));
            chk($sformatf("vec%0d.hit", i), int'(query_hit), int'(tv[i].hit));
            chk($sformatf("vec%0d.moved", i), int'(moved), int'(tv[i].mv));
            chk($sformatf("vec%0d.go", i), int'(game_over), int'(tv[i].go));
        end
        rst = 1'b0;
        step = 1'b0;
        dir_valid = 1'b0;
        is_eat = 1'b0;

        // wrap-around on all four edges
        do_reset();
        repeat (23) tick(1, 0, 0, 0);
        st("wrap_r_pre", 31, 12, 3, 0);
        tick(1, 0, 0, 0);
        st("wrap_r", 0, 12, 3, 0);
        tick(0, 1, DIR_UP, 0);
        repeat (12) tick(1, 0, 0, 0);
        st("wrap_u_pre", 0, 0, 3, 0);
        tick(1, 0, 0, 0);
        st("wrap_u", 0, 23, 3, 0);
        tick(0, 1, DIR_LEFT, 0);
        tick(1, 0, 0, 0);
        st("wrap_l", 31, 23, 3, 0);
        tick(0, 1, DIR_DOWN, 0);
        tick(1, 0, 0, 0);
        st("wrap_d", 31, 0, 3, 0);
        tick(0, 1, DIR_RIGHT, 0);
        tick(1, 0, 0, 0);
        st("wrap_r2", 0, 0, 3, 0);

        // eat pulses between steps count once; tail stays on the growing step
        do_reset();
        repeat (4) tick(0, 0, 0, 1);
        tick(1, 0, 0, 0);
        st("eat_grow", 9, 12, 4, 0);
        qchk("eat_tail_kept", 6, 12, 1);
        tick(1, 0, 0, 0);
        st("eat_once", 10, 12, 4, 0);
        qchk("eat_tail_moved", 6, 12, 0);
        tick(1, 0, 0, 1);
        st("eat_same_cycle", 11, 12, 5, 0);

        // saturation: full row of 32, head chases the vacating tail
        do_reset();
        repeat (29) tick(1, 0, 0, 1);
        st("sat_fill", 5, 12, 32, 0);
        tick(1, 0, 0, 1);
        st("sat_eat", 6, 12, 32, 0);
        tick(1, 0, 0, 0);
        st("sat_step", 7, 12, 32, 0);
        qchk("sat_q_row", 20, 12, 1);
        qchk("sat_q_off", 20, 13, 0);

        // self-collision at length 5, then freeze, then reset
        do_reset();
        tick(1, 0, 0, 1);
        tick(1, 0, 0, 1);
        st("die_len5", 10, 12, 5, 0);
        tick(0, 1, DIR_DOWN, 0);
        tick(1, 0, 0, 0);
        tick(0, 1, DIR_LEFT, 0);
        tick(1, 0, 0, 0);
        st("die_pre", 9, 13, 5, 0);
        tick(0, 1, DIR_UP, 0);
        tick(1, 0, 0, 0);
        st("die_hit", 9, 13, 5, 1);
        chk("die_moved", int'(moved), 0);
        tick(1, 1, DIR_RIGHT, 1);
        tick(1, 0, 0, 1);
        st("die_frozen", 9, 13, 5, 1);
        do_reset();
        st("die_rst", 8, 12, 3, 0);
        tick(1, 0, 0, 0);
        st("die_rst_step", 9, 12, 3, 0);

        // 2x2 loop at length 4: tail cell is free unless growing
        do_reset();
        tick(1, 0, 0, 1);
        tick(0, 1, DIR_DOWN, 0);
        tick(1, 0, 0, 0);
        tick(0, 1, DIR_LEFT, 0);
        tick(1, 0, 0, 0);
        tick(0, 1, DIR_UP, 0);
        tick(1, 0, 0, 0);
        st("loop_up", 8, 12, 4, 0);
        tick(0, 1, DIR_RIGHT, 0);
        tick(1, 0, 0, 0);
        st("loop_right", 9, 12, 4, 0);
        tick(0, 1, DIR_DOWN, 0);
        tick(1, 0, 0, 1);
        st("loop_eat_die", 9, 12, 4, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/snake_body.md
# snake_body

Snake movement and body-storage stage on the 32x24 logical grid. It sits directly upstream of the apple spawner: it drives the head coordinate (`head_x`, `head_y`) and `length` that the spawner compares against, and it consumes the spawner's `is_eat`. It also serves cell-occupancy queries to the renderer and flags self-collision as game over.

## Interface
**Parameters**
- `H_LOGIC_WIDTH`, default 5: width of a logical X coordinate.
- `V_LOGIC_WIDTH`, default 5: width of a logical Y coordinate.
- `H_LOGIC_MAX`, default 31: largest logical X.
- `V_LOGIC_MAX`, default 23: largest logical Y.
- `MAX_LEN`, default 32: number of segment slots; length saturates here.
- `INIT_LEN`, default 3: length after reset.

**Ports**
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `step`, input, 1: one-cycle move tick.
- `dir_valid`, input, 1: `dir_req` is valid this cycle.
- `dir_req`, input, 2: requested direction; 0 = up, 1 = right, 2 = down, 3 = left.
- `is_eat`, input, 1: head is on the apple (combinational, from the apple spawner).
- `query_x`, input, `H_LOGIC_WIDTH`: X of the renderer's cell query.
- `query_y`, input, `V_LOGIC_WIDTH`: Y of the renderer's cell query.
- `head_x`, output, `H_LOGIC_WIDTH`: head X, registered.
- `head_y`, output, `V_LOGIC_WIDTH`: head Y, registered.
- `length`, output, 10: current segment count, registered.
- `query_hit`, output, 1: combinational; the query cell is occupied by any live segment.
- `moved`, output, 1: one-cycle pulse, the cycle after a committed move.
- `game_over`, output, 1: sticky self-collision flag.

## Operation
- **Storage:** `seg[0..MAX_LEN-1]` holds (x, y) per slot; `seg[0]` is the head. Slots at index ≥ `length` are don't-care.
- **Reset state:**
  - `seg[0]` = (8,12), `seg[1]` = (7,12), `seg[2]` = (6,12).
  - `dir` = right, `dir_pend` = right, `length` = `INIT_LEN`.
  - `eat_pend` = 0, `moved` = 0, `game_over` = 0, state RUN.
- **States:**
  - RUN: moves are processed.
  - DEAD: all inputs except `rst` are ignored; outputs are frozen. Only `rst` leaves DEAD.
- **Direction:**
  - On `dir_valid`, load `dir_pend` with `dir_req` unless it is the opposite of committed `dir`. Compare as `dir_req == dir ^ 2`; such a request is dropped.
  - Compare against committed `dir`, not `dir_pend`.
  - `dir_pend` is copied to `dir` on each committed step.
- **Eat:**
  - `eat_pend` is set on any cycle with `is_eat` = 1 in RUN and cleared on a committed step.
  - Multiple `is_eat` cycles between steps count as one growth.
- **Next head:** computed from `seg[0]` and `dir_pend`, with wrap-around:
  - X: 31+1 → 0, 0−1 → 31.
  - Y: 23+1 → 0, 0−1 → 23.
- **Step in RUN:**
  - `grow` = (`eat_pend` OR `is_eat`) AND `length` < `MAX_LEN`.
  - Collision set: slots `i` < `length`−1 when `grow` = 0 (the tail vacates); slots `i` < `length` when `grow` = 1.
  - Next head in the collision set: go to DEAD, assert `game_over`, move nothing.
  - Otherwise: `seg[i]` ← `seg[i-1]` for all `i` ≥ 1, `seg[0]` ← next head, and `length` += `grow`.
- **Saturation:** at `length` = `MAX_LEN`, eating still clears `eat_pend` but does not grow.
- **Query:** `query_hit` = OR over `i` < `length` of (`seg[i]` == query).

## Timing
- `head_x`/`head_y`, `length`, `dir` and `moved` update on the clock edge that samples `step`; they are visible 1 cycle later.
- `game_over` rises 1 cycle after the colliding `step`.
- `step` and `dir_valid` in the same cycle: the step uses the old `dir_pend`; the new request applies to the next step.
- `step` and `is_eat` in the same cycle: counts as growth for that step.
- `rst` mid-operation, including in DEAD, restores the full reset state on the next edge. `rst` wins over a simultaneous `step`.
- `step` held high for multiple cycles: one move per high cycle. No internal edge detection.

## Structure
- **Package `snake_pkg`:**
  - Direction encoding constants `DIR_UP`/`DIR_RIGHT`/`DIR_DOWN`/`DIR_LEFT`.
  - Grid maxima.
  - Reset head position (8,12), `INIT_LEN`, and the `MAX_LEN` default.
  - Coordinate-pair struct.
- **Sub-module `snake_next_head`:** combinational; takes head and direction, produces the wrapped next head. It is reused by the AI/demo controller.
- **Top:** segment register array, RUN/DEAD FSM, collision and query comparators.

## Test plan
- Reset, then 3 steps with no input → head (11,12), `length` 3, `seg[2]` = (9,12), `game_over` 0.
- Head at (31,12) moving right, 1 step → head (0,12). Head at (5,0) moving up, 1 step → head (5,23).
- From reset, `dir_req` = left → ignored, head (9,12) after the step. `dir_req` = down → head (8,13) after the step.
- Pulse `is_eat` for 4 cycles, then step → `length` 4, tail unchanged. Step again → `length` 4. Force `length` 32 and eat → `length` stays 32.
- Length 5 with turns down, left, up on consecutive steps → `game_over` = 1 the cycle after the 3rd step, head frozen, further steps ignored. Then `rst` → reset state.
- Length 4 in a 2x2 loop, no eat → the head entering the vacating tail cell does not collide. Same loop with `is_eat` asserted → `game_over`.
